// File: rtl/pkt_arbiter.sv
// Round-robin packet arbiter: picks one of four source FIFOs and frames its
// bytes as SYNC, header, payload (up to MAX_BURST bytes) and XOR checksum.
module pkt_arbiter #(
  parameter int          NUM_SRC   = 4,
  parameter int          LVL_W     = 5,
  parameter int          MAX_BURST = 15,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NUM_SRC*LVL_W-1:0] src_level,
  input  logic [NUM_SRC*8-1:0]     src_data,
  output logic [NUM_SRC-1:0]       src_rd_en,
  output logic [7:0]               pkt_data,
  output logic                     pkt_valid,
  input  logic                     pkt_ready,
  output logic                     busy,
  output logic [1:0]               cur_src,
  output logic [2:0]               debug_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB     = 3'd1,
    SYNC    = 3'd2,
    HDR     = 3'd3,
    PAYLOAD = 3'd4,
    CSUM    = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(MAX_BURST);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        last_grant;
  logic [3:0]        len;
  logic [3:0]        byte_cnt;
  logic [7:0]        checksum;
  logic              win_found;
  logic [1:0]        win_src;
  logic [1:0]        cand;
  logic [LVL_W-1:0]  win_lvl;
  logic [3:0]        win_len;
  logic [7:0]        hdr_byte;
  logic [7:0]        cur_byte;

  assign hdr_byte    = {cur_src, 2'b00, len};
  assign cur_byte    = src_data[cur_src*8 +: 8];
  assign busy        = (state != IDLE);
  assign debug_state = state;

  // Round-robin search beginning just after the last granted source; the
  // winning length is clipped to the burst limit.
  always_comb begin
    win_found = 1'b0;
    win_src   = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = last_grant + 2'(k);
      if (!win_found && (src_level[cand*LVL_W +: LVL_W] != '0)) begin
        win_found = 1'b1;
        win_src   = cand;
      end
    end
    win_lvl = src_level[win_src*LVL_W +: LVL_W];
    win_len = (win_lvl > MAX_LVL) ? MAX_LVL[3:0] : win_lvl[3:0];
  end

  // State register, cleared asynchronously so an interrupted packet is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; pops happen only on accepted payload bytes.
  always_comb begin
    state_nxt = state;
    pkt_valid = 1'b0;
    pkt_data  = 8'h00;
    src_rd_en = '0;
    case (state)
      IDLE: begin
        if (enable && win_found) state_nxt = ARB;
      end
      ARB: begin
        state_nxt = win_found ? SYNC : IDLE;
      end
      SYNC: begin
        pkt_valid = 1'b1;
        pkt_data  = SYNC_BYTE;
        if (pkt_ready) state_nxt = HDR;
      end
      HDR: begin
        pkt_valid = 1'b1;
        pkt_data  = hdr_byte;
        if (pkt_ready) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        pkt_valid = 1'b1;
        pkt_data  = cur_byte;
        if (pkt_ready) begin
          src_rd_en[cur_src] = 1'b1;
          if (byte_cnt == len - 4'd1) state_nxt = CSUM;
        end
      end
      CSUM: begin
        pkt_valid = 1'b1;
        pkt_data  = checksum;
        if (pkt_ready) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Packet bookkeeping: grant latching in ARB, running checksum and byte count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 2'd3;
      cur_src    <= 2'd0;
      len        <= 4'd0;
      byte_cnt   <= 4'd0;
      checksum   <= 8'h00;
    end else begin
      case (state)
        ARB: begin
          if (win_found) begin
            cur_src    <= win_src;
            last_grant <= win_src;
            len        <= win_len;
            byte_cnt   <= 4'd0;
            checksum   <= 8'h00;
          end
        end
        HDR: begin
          if (pkt_ready) checksum <= hdr_byte;
        end
        PAYLOAD: begin
          if (pkt_ready) begin
            checksum <= checksum ^ cur_byte;
            byte_cnt <= byte_cnt + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_arbiter.sv
// Self-checking bench for pkt_arbiter: cycle table, directed corner cases and
// randomized FIFO contents scored against a packet-level reference model.
`timescale 1ns/1ps
module tb_pkt_arbiter;

  localparam int         LVL_W     = 5;
  localparam int         MAX_BURST = 15;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             pkt_ready = 1'b0;
  logic [4*LVL_W-1:0] src_level = '0;
  logic [31:0]      src_data = '0;
  logic [3:0]       src_rd_en;
  logic [7:0]       pkt_data;
  logic             pkt_valid;
  logic             busy;
  logic [1:0]       cur_src;
  logic [2:0]       debug_state;

  pkt_arbiter #(
    .NUM_SRC(4), .LVL_W(LVL_W), .MAX_BURST(MAX_BURST), .SYNC_BYTE(SYNC_BYTE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .src_level(src_level), .src_data(src_data), .src_rd_en(src_rd_en),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .busy(busy), .cur_src(cur_src), .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [3:0] rd;
    bit         is_hdr;
  } exp_t;

  typedef struct {
    logic       en;
    logic       rdy;
    logic [2:0] st;
    logic       vld;
    logic [7:0] dat;
    logic [3:0] rd;
    logic       bsy;
    logic [1:0] cur;
  } vec_t;

  logic [7:0] fifo_q [4][$];
  logic [7:0] model_q[4][$];
  exp_t       exp_q[$];
  logic [7:0] hdr_log[$];
  vec_t       vecs[$];
  int         model_last = 3;
  int         checks = 0;
  int         errors = 0;
  int         ready_mode = 3;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  // FWFT FIFO model drives levels and head bytes; ready follows the chosen mode
  task automatic applyStimulus();
    for (int i = 0; i < 4; i++) begin
      src_level[i*LVL_W +: LVL_W] = LVL_W'(fifo_q[i].size());
      src_data[i*8 +: 8] = (fifo_q[i].size() > 0) ? fifo_q[i][0] : 8'h00;
    end
    case (ready_mode)
      0:       pkt_ready = 1'b1;
      1:       pkt_ready = ~pkt_ready;
      2:       pkt_ready = 1'($urandom_range(0, 1));
      default: pkt_ready = pkt_ready;
    endcase
  endtask

  task automatic load_src(input int s, input int n);
    logic [7:0] b;
    for (int j = 0; j < n; j++) begin
      b = 8'($urandom);
      fifo_q[s].push_back(b);
      model_q[s].push_back(b);
    end
  endtask

  function automatic bit model_empty();
    model_empty = 1'b1;
    for (int i = 0; i < 4; i++) if (model_q[i].size() != 0) model_empty = 1'b0;
  endfunction

  // Whole-packet prediction: round-robin pick, clipped length, XOR checksum
  task automatic predict_packet();
    int w;
    int n;
    logic [7:0] hdr;
    logic [7:0] cs;
    logic [7:0] b;
    w = -1;
    for (int k = 1; k <= 4; k++) begin
      if (w < 0 && model_q[(model_last + k) % 4].size() > 0) w = (model_last + k) % 4;
    end
    if (w < 0) return;
    n   = (model_q[w].size() > MAX_BURST) ? MAX_BURST : model_q[w].size();
    hdr = 8'(w * 64 + n);
    exp_q.push_back('{data: SYNC_BYTE, rd: 4'h0, is_hdr: 1'b0});
    exp_q.push_back('{data: hdr, rd: 4'h0, is_hdr: 1'b1});
    cs = hdr;
    for (int j = 0; j < n; j++) begin
      b  = model_q[w].pop_front();
      cs = cs ^ b;
      exp_q.push_back('{data: b, rd: 4'(1 << w), is_hdr: 1'b0});
    end
    exp_q.push_back('{data: cs, rd: 4'h0, is_hdr: 1'b0});
    model_last = w;
  endtask

  task automatic score_cycle();
    exp_t e;
    if (prev_stall) begin
      checkOutput("stall_valid_held", 32'(pkt_valid), 32'd1);
      checkOutput("stall_data_held", 32'(pkt_data), 32'(prev_data));
    end
    if (pkt_valid && pkt_ready) begin
      if (exp_q.size() == 0) predict_packet();
      if (exp_q.size() == 0) begin
        fail_now("unexpected_transfer");
      end else begin
        e = exp_q.pop_front();
        checkOutput("pkt_byte", 32'(pkt_data), 32'(e.data));
        checkOutput("pop_on_transfer", 32'(src_rd_en), 32'(e.rd));
        if (e.is_hdr) hdr_log.push_back(pkt_data);
      end
    end else begin
      checkOutput("no_pop_without_transfer", 32'(src_rd_en), 32'd0);
    end
    if (!pkt_valid) checkOutput("data_zero_when_invalid", 32'(pkt_data), 32'd0);
    prev_stall = pkt_valid && !pkt_ready;
    prev_data  = pkt_data;
  endtask

  task automatic check_row(input int r);
    checkOutput($sformatf("row%0d_state", r), 32'(debug_state), 32'(vecs[r].st));
    checkOutput($sformatf("row%0d_valid", r), 32'(pkt_valid), 32'(vecs[r].vld));
    checkOutput($sformatf("row%0d_data", r), 32'(pkt_data), 32'(vecs[r].dat));
    checkOutput($sformatf("row%0d_rd_en", r), 32'(src_rd_en), 32'(vecs[r].rd));
    checkOutput($sformatf("row%0d_busy", r), 32'(busy), 32'(vecs[r].bsy));
    checkOutput($sformatf("row%0d_cur_src", r), 32'(cur_src), 32'(vecs[r].cur));
  endtask

  // One cycle: drive at negedge, sample 1ns later, cross posedge, pop FIFOs
  task automatic step_cycle(input bit score, input int row);
    logic [3:0] rd_seen;
    applyStimulus();
    #1;
    if (score) score_cycle();
    if (row >= 0) check_row(row);
    rd_seen = src_rd_en;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (rd_seen[i] && fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
    end
    @(negedge clk);
  endtask

  task automatic run_until_idle(input int budget);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    prev_stall = 1'b0;
    while (!done && n < budget) begin
      step_cycle(1'b1, -1);
      n++;
      if (exp_q.size() == 0 && model_empty() && !busy) done = 1'b1;
    end
    if (!done) fail_now("run_timeout");
    for (int i = 0; i < 4; i++) checkOutput($sformatf("fifo%0d_drained", i), 32'(fifo_q[i].size()), 32'd0);
  endtask

  task automatic sync_model();
    for (int i = 0; i < 4; i++) model_q[i] = fifo_q[i];
    exp_q.delete();
    model_last = 3;
    prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sync_model();
  endtask

  task automatic add_row(input logic en, input logic rdy, input logic [2:0] st, input logic vld,
                         input logic [7:0] dat, input logic [3:0] rd, input logic bsy, input logic [1:0] cur);
    vecs.push_back('{en: en, rdy: rdy, st: st, vld: vld, dat: dat, rd: rd, bsy: bsy, cur: cur});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] fair_hdr [4];
    int         n;
    bit         done;
    fair_hdr = '{8'h01, 8'h41, 8'h81, 8'hC1};

    // Single packet from src1 with one stall in HDR and one in PAYLOAD
    add_row(1, 1, 3'd0, 0, 8'h00, 4'h0, 0, 2'd0);
    add_row(1, 1, 3'd1, 0, 8'h00, 4'h0, 1, 2'd0);
    add_row(1, 1, 3'd2, 1, 8'hA5, 4'h0, 1, 2'd1);
    add_row(1, 0, 3'd3, 1, 8'h43, 4'h0, 1, 2'd1);
    add_row(1, 1, 3'd3, 1, 8'h43, 4'h0, 1, 2'd1);
    add_row(1, 1, 3'd4, 1, 8'h11, 4'h2, 1, 2'd1);
    add_row(1, 0, 3'd4, 1, 8'h22, 4'h0, 1, 2'd1);
    add_row(1, 1, 3'd4, 1, 8'h22, 4'h2, 1, 2'd1);
    add_row(1, 1, 3'd4, 1, 8'h33, 4'h2, 1, 2'd1);
    add_row(1, 1, 3'd5, 1, 8'h43, 4'h0, 1, 2'd1);
    add_row(1, 1, 3'd6, 0, 8'h00, 4'h0, 1, 2'd1);
    add_row(1, 1, 3'd0, 0, 8'h00, 4'h0, 0, 2'd1);
    add_row(1, 1, 3'd0, 0, 8'h00, 4'h0, 0, 2'd1);

    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("reset_valid", 32'(pkt_valid), 32'd0);
    checkOutput("reset_data", 32'(pkt_data), 32'd0);
    checkOutput("reset_rd_en", 32'(src_rd_en), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_state", 32'(debug_state), 32'd0);
    checkOutput("reset_cur_src", 32'(cur_src), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    fifo_q[1].push_back(8'h11);
    fifo_q[1].push_back(8'h22);
    fifo_q[1].push_back(8'h33);
    ready_mode = 3;
    for (int r = 0; r < vecs.size(); r++) begin
      enable    = vecs[r].en;
      pkt_ready = vecs[r].rdy;
      step_cycle(1'b0, r);
    end
    checkOutput("table_src1_drained", 32'(fifo_q[1].size()), 32'd0);

    // Fairness after reset: one byte in every source
    do_reset();
    for (int i = 0; i < 4; i++) load_src(i, 1);
    hdr_log.delete();
    ready_mode = 0;
    enable = 1'b1;
    run_until_idle(200);
    checkOutput("fair_hdr_count", 32'(hdr_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("fair_hdr%0d", i), 32'(hdr_log[i]), 32'(fair_hdr[i]));

    // Burst cap: 20 bytes split into 15 + 5
    load_src(2, 20);
    hdr_log.delete();
    run_until_idle(300);
    checkOutput("burst_hdr_count", 32'(hdr_log.size()), 32'd2);
    checkOutput("burst_hdr0", 32'(hdr_log[0]), 32'h8F);
    checkOutput("burst_hdr1", 32'(hdr_log[1]), 32'h85);

    // Backpressure: ready toggles every cycle
    load_src(3, 9);
    load_src(0, 4);
    hdr_log.delete();
    ready_mode = 1;
    run_until_idle(300);
    checkOutput("bp_hdr0", 32'(hdr_log[0]), 32'hC9);
    checkOutput("bp_hdr1", 32'(hdr_log[1]), 32'h04);

    // Reset two bytes into a src1 payload
    ready_mode = 0;
    load_src(1, 10);
    load_src(3, 3);
    hdr_log.delete();
    prev_stall = 1'b0;
    repeat (6) step_cycle(1'b1, -1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(pkt_valid), 32'd0);
    checkOutput("midrst_data", 32'(pkt_data), 32'd0);
    checkOutput("midrst_rd_en", 32'(src_rd_en), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_state", 32'(debug_state), 32'd0);
    checkOutput("midrst_cur_src", 32'(cur_src), 32'd0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("midrst_hold_rd_en", 32'(src_rd_en), 32'd0);
    end
    rst_n = 1'b1;
    checkOutput("midrst_src1_left", 32'(fifo_q[1].size()), 32'd8);
    sync_model();
    hdr_log.delete();
    run_until_idle(300);
    checkOutput("midrst_hdr0", 32'(hdr_log[0]), 32'h48);
    checkOutput("midrst_hdr1", 32'(hdr_log[1]), 32'hC3);

    // enable low holds IDLE; dropping enable in HDR finishes only that packet
    enable = 1'b0;
    load_src(0, 2);
    load_src(2, 3);
    hdr_log.delete();
    prev_stall = 1'b0;
    repeat (10) begin
      step_cycle(1'b0, -1);
      checkOutput("en_low_state", 32'(debug_state), 32'd0);
      checkOutput("en_low_rd_en", 32'(src_rd_en), 32'd0);
    end
    enable = 1'b1;
    repeat (3) step_cycle(1'b1, -1);
    enable = 1'b0;
    n = 0;
    done = 1'b0;
    while (!done && n < 50) begin
      step_cycle(1'b1, -1);
      n++;
      if (exp_q.size() == 0 && !busy && hdr_log.size() > 0) done = 1'b1;
    end
    if (!done) fail_now("en_drop_timeout");
    repeat (20) step_cycle(1'b1, -1);
    checkOutput("en_drop_pkts", 32'(hdr_log.size()), 32'd1);
    checkOutput("en_drop_hdr", 32'(hdr_log[0]), 32'h02);
    checkOutput("en_drop_src2_kept", 32'(fifo_q[2].size()), 32'd3);
    checkOutput("en_drop_idle", 32'(debug_state), 32'd0);

    // Randomized FIFO fills and ready patterns
    for (int it = 0; it < 8; it++) begin
      enable = 1'b0;
      for (int i = 0; i < 4; i++) load_src(i, $urandom_range(0, 22));
      if (model_empty()) load_src($urandom_range(0, 3), 1 + $urandom_range(0, 20));
      ready_mode = $urandom_range(0, 2);
      enable = 1'b1;
      run_until_idle(3000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
